// File: rtl/cpu_run_monitor_pkg.sv
// Shared definitions for the CPU run/check monitor: default widths and FSM states.
package cpu_run_monitor_pkg;

  localparam int DEF_DATA_W      = 32;
  localparam int DEF_PC_W        = 32;
  localparam int DEF_NREG        = 32;
  localparam int DEF_TRACE_DEPTH = 16;
  localparam int DEF_CYC_W       = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } mon_state_e;

endpackage

// File: rtl/cpu_run_monitor_trace_ring.sv
// Circular PC/instruction trace. Reads are relative to the oldest live entry;
// indices at or beyond the live count read as zero.
module trace_ring #(
  parameter int PC_W   = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              we,
  input  logic [PC_W-1:0]   wpc,
  input  logic [DATA_W-1:0] winstr,
  input  logic [AW-1:0]     raddr,
  output logic [PC_W-1:0]   rpc,
  output logic [DATA_W-1:0] rinstr,
  output logic [AW:0]       count
);

  logic [PC_W-1:0]   pc_mem    [DEPTH];
  logic [DATA_W-1:0] instr_mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_idx;

  // Storage only; liveness is tracked by count, so the array needs no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      pc_mem[wr_ptr]    <= wpc;
      instr_mem[wr_ptr] <= winstr;
    end
  end

  // Write pointer advances every write; count saturates at DEPTH so a wrap
  // silently overwrites the oldest entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (we) begin
      wr_ptr <= wr_ptr + 1'b1;
      if (count != (AW+1)'(DEPTH))
        count <= count + 1'b1;
    end
  end

  // Oldest-relative read: physical = wr_ptr - count + raddr (mod DEPTH).
  always_comb begin
    rd_idx = wr_ptr - count[AW-1:0] + raddr;
    rpc    = '0;
    rinstr = '0;
    if ({1'b0, raddr} < count) begin
      rpc    = pc_mem[rd_idx];
      rinstr = instr_mem[rd_idx];
    end
  end

endmodule

// File: rtl/cpu_run_monitor.sv
// Run/check monitor beside the single-cycle CPU: snoops the run, stops on a
// PC self-loop or cycle limit, then checks a shadow register file against a
// programmed expected table, one register per cycle.
//
// Handshake: start is a request sampled only in IDLE/DONE (ignored while busy);
// completion is signalled by done, which stays high with all results stable
// until the next accepted start or reset.
module cpu_run_monitor
  import cpu_run_monitor_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int PC_W        = DEF_PC_W,
  parameter int NREG        = DEF_NREG,
  parameter int TRACE_DEPTH = DEF_TRACE_DEPTH,
  parameter int CYC_W       = DEF_CYC_W,
  parameter int REG_AW      = $clog2(NREG),
  parameter int TR_AW       = $clog2(TRACE_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CYC_W-1:0]  max_cycles,
  input  logic [PC_W-1:0]   pc,
  input  logic [DATA_W-1:0] instruction,
  input  logic              rf_we,
  input  logic [REG_AW-1:0] rf_waddr,
  input  logic [DATA_W-1:0] rf_wdata,
  input  logic              exp_we,
  input  logic              exp_clr,
  input  logic [REG_AW-1:0] exp_addr,
  input  logic [DATA_W-1:0] exp_data,
  input  logic [TR_AW-1:0]  trace_raddr,
  output logic [PC_W-1:0]   trace_pc,
  output logic [DATA_W-1:0] trace_instr,
  output logic [TR_AW:0]    trace_count,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              halted,
  output logic              timeout,
  output logic [CYC_W-1:0]  cycle_count,
  output logic [REG_AW:0]   mismatch_count,
  output logic [REG_AW-1:0] first_mismatch_reg,
  output logic [1:0]        dbg_state
);

  mon_state_e        state_q, state_d;
  logic [PC_W-1:0]   prev_pc;
  logic [REG_AW-1:0] check_i;
  logic [DATA_W-1:0] shadow  [NREG];
  logic [DATA_W-1:0] exp_mem [NREG];
  logic [NREG-1:0]   exp_valid;

  logic idle_like, run_entry, in_run, in_check, halt_hit, to_hit, check_last;

  assign idle_like  = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign run_entry  = idle_like && start;
  assign in_run     = (state_q == ST_RUN);
  assign in_check   = (state_q == ST_CHECK);
  // Exit conditions use the cycle's pre-update counter and previous PC.
  assign halt_hit   = in_run && (cycle_count != '0) && (pc == prev_pc);
  assign to_hit     = in_run && (max_cycles != '0) &&
                      (({1'b0, cycle_count} + {{CYC_W{1'b0}}, 1'b1}) == {1'b0, max_cycles});
  assign check_last = (check_i == REG_AW'(NREG - 1));

  assign busy      = in_run || in_check;
  assign done      = (state_q == ST_DONE);
  assign pass      = done && (mismatch_count == '0);
  assign dbg_state = state_q;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: IDLE/DONE -> RUN on start, RUN -> CHECK on halt/timeout,
  // CHECK -> DONE after the last register.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = ST_RUN;
      ST_RUN:           if (halt_hit || to_hit) state_d = ST_CHECK;
      ST_CHECK:         if (check_last) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  // Run bookkeeping: saturating cycle counter, previous PC, exit flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_count <= '0;
      prev_pc     <= '0;
      halted      <= 1'b0;
      timeout     <= 1'b0;
    end else if (run_entry) begin
      cycle_count <= '0;
      prev_pc     <= '0;
      halted      <= 1'b0;
      timeout     <= 1'b0;
    end else if (in_run) begin
      if (cycle_count != '1) cycle_count <= cycle_count + 1'b1;
      prev_pc <= pc;
      if (halt_hit) halted  <= 1'b1;
      if (to_hit)   timeout <= 1'b1;
    end
  end

  // Shadow register file; register 0 is hardwired to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NREG; k++) shadow[k] <= '0;
    end else if (run_entry) begin
      for (int k = 0; k < NREG; k++) shadow[k] <= '0;
    end else if (in_run && rf_we && (rf_waddr != '0)) begin
      shadow[rf_waddr] <= rf_wdata;
    end
  end

  // Expected table, writable only while not busy; a same-cycle clear and
  // write leaves just the written entry valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_valid <= '0;
      for (int k = 0; k < NREG; k++) exp_mem[k] <= '0;
    end else if (idle_like) begin
      if (exp_clr) exp_valid <= '0;
      if (exp_we) begin
        exp_valid[exp_addr] <= 1'b1;
        exp_mem[exp_addr]   <= exp_data;
      end
    end
  end

  // Check sweep: one register per cycle, counting mismatches and latching
  // the lowest failing index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      check_i            <= '0;
      mismatch_count     <= '0;
      first_mismatch_reg <= '0;
    end else if (run_entry) begin
      check_i            <= '0;
      mismatch_count     <= '0;
      first_mismatch_reg <= '0;
    end else if (in_check) begin
      check_i <= check_i + 1'b1;
      if (exp_valid[check_i] && (shadow[check_i] != exp_mem[check_i])) begin
        mismatch_count <= mismatch_count + 1'b1;
        if (mismatch_count == '0) first_mismatch_reg <= check_i;
      end
    end
  end

  trace_ring #(
    .PC_W   (PC_W),
    .DATA_W (DATA_W),
    .DEPTH  (TRACE_DEPTH),
    .AW     (TR_AW)
  ) u_trace (
    .clk    (clk),
    .rst    (reset),
    .clr    (run_entry),
    .we     (in_run),
    .wpc    (pc),
    .winstr (instruction),
    .raddr  (trace_raddr),
    .rpc    (trace_pc),
    .rinstr (trace_instr),
    .count  (trace_count)
  );

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Bench for cpu_run_monitor: directed runs, expected results queued at issue
// time and compared by a monitor whenever done rises.
module tb_cpu_run_monitor;

  localparam int RES_W = 31;
  localparam logic [1:0] ST_CHECK_ENC = 2'd2;
  localparam logic [31:0] ADDI = 32'h0050_0813;
  localparam logic [31:0] JMP  = 32'h0000_006f;

  logic        clk = 1'b0;
  logic        reset, start, rf_we, exp_we, exp_clr;
  logic [15:0] max_cycles;
  logic [31:0] pc, instruction, rf_wdata, exp_data;
  logic [4:0]  rf_waddr, exp_addr;
  logic [3:0]  trace_raddr;
  logic [31:0] trace_pc, trace_instr;
  logic [4:0]  trace_count;
  logic        busy, done, pass, halted, timeout;
  logic [15:0] cycle_count;
  logic [5:0]  mismatch_count;
  logic [4:0]  first_mismatch_reg;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;
  logic [RES_W-1:0] exp_q[$];
  logic done_prev = 1'b0;

  cpu_run_monitor dut (
    .clk(clk), .reset(reset), .start(start), .max_cycles(max_cycles),
    .pc(pc), .instruction(instruction), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .exp_we(exp_we), .exp_clr(exp_clr), .exp_addr(exp_addr),
    .exp_data(exp_data), .trace_raddr(trace_raddr), .trace_pc(trace_pc),
    .trace_instr(trace_instr), .trace_count(trace_count), .busy(busy), .done(done),
    .pass(pass), .halted(halted), .timeout(timeout), .cycle_count(cycle_count),
    .mismatch_count(mismatch_count), .first_mismatch_reg(first_mismatch_reg),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    reset = 1'b1; start = 1'b0; max_cycles = '0; pc = '0; instruction = '0;
    rf_we = 1'b0; rf_waddr = '0; rf_wdata = '0; exp_we = 1'b0; exp_clr = 1'b0;
    exp_addr = '0; exp_data = '0; trace_raddr = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  function automatic logic [RES_W-1:0] pack_res(input logic h, input logic t, input logic p,
      input logic [15:0] cyc, input logic [5:0] mm, input logic [4:0] fm);
    return {1'b0, h, t, p, cyc, mm, fm};
  endfunction

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic prog_exp(input logic [4:0] a, input logic [31:0] d);
    exp_we = 1'b1; exp_addr = a; exp_data = d;
    @(posedge clk); #1;
    exp_we = 1'b0;
  endtask

  task automatic clr_exp();
    exp_clr = 1'b1;
    @(posedge clk); #1;
    exp_clr = 1'b0;
  endtask

  task automatic start_run();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drive_cycle(input logic [31:0] p, input logic [31:0] ins,
      input logic we, input logic [4:0] wa, input logic [31:0] wd);
    pc = p; instruction = ins; rf_we = we; rf_waddr = wa; rf_wdata = wd;
    @(posedge clk); #1;
    rf_we = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL %s_done_wait actual=timeout required=done", name);
    end
    @(posedge clk); #1;
  endtask

  task automatic read_trace(input string name, input logic [3:0] idx,
      input logic [31:0] epc, input logic [31:0] eins);
    trace_raddr = idx;
    #1;
    check({name, "_pc"}, trace_pc, epc);
    check({name, "_instr"}, trace_instr, eins);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (done && !done_prev) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL result_unexpected actual=%0h required=no_result",
                 {busy, halted, timeout, pass, cycle_count, mismatch_count, first_mismatch_reg});
      end else begin
        logic [RES_W-1:0] e;
        logic [RES_W-1:0] a;
        e = exp_q.pop_front();
        a = {busy, halted, timeout, pass, cycle_count, mismatch_count, first_mismatch_reg};
        if (a !== e) begin
          failures++;
          $display("FAIL run_result actual=%0h required=%0h", a, e);
        end
      end
    end
    done_prev = done;
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    apply_reset();
    check("reset_outputs",
          {busy, done, pass, halted, timeout, cycle_count, mismatch_count,
           first_mismatch_reg, trace_count, trace_pc, trace_instr, dbg_state}, '0);

    // 1: r16 expected 5, addi then jump-to-self -> halt after 3 cycles, pass.
    prog_exp(5'd16, 32'd5);
    exp_q.push_back(pack_res(1'b1, 1'b0, 1'b1, 16'd3, 6'd0, 5'd0));
    start_run();
    drive_cycle(32'h0, ADDI, 1'b1, 5'd16, 32'd5);
    drive_cycle(32'h8, JMP, 1'b0, 5'd0, 32'd0);
    drive_cycle(32'h8, JMP, 1'b0, 5'd0, 32'd0);
    wait_done("t1");
    check("t1_trace_count", trace_count, 5'd3);
    read_trace("t1_tr0", 4'd0, 32'h0, ADDI);
    read_trace("t1_tr2", 4'd2, 32'h8, JMP);

    // 2: same-cycle clear+write r16=6, then r17=0 -> one mismatch at r16.
    exp_clr = 1'b1;
    prog_exp(5'd16, 32'd6);
    exp_clr = 1'b0;
    prog_exp(5'd17, 32'd0);
    exp_q.push_back(pack_res(1'b1, 1'b0, 1'b0, 16'd3, 6'd1, 5'd16));
    start_run();
    drive_cycle(32'h0, ADDI, 1'b1, 5'd16, 32'd5);
    drive_cycle(32'h8, JMP, 1'b0, 5'd0, 32'd0);
    drive_cycle(32'h8, JMP, 1'b0, 5'd0, 32'd0);
    wait_done("t2");

    // 3: timeout at 3 cycles with linear PC; empty table -> pass.
    clr_exp();
    max_cycles = 16'd3;
    exp_q.push_back(pack_res(1'b0, 1'b1, 1'b1, 16'd3, 6'd0, 5'd0));
    start_run();
    for (int i = 0; i < 3; i++) drive_cycle(32'(4 * i), 32'h1000_0000 + 32'(i), 1'b0, 5'd0, 32'd0);
    wait_done("t3");
    check("t3_trace_count", trace_count, 5'd3);
    read_trace("t3_tr2", 4'd2, 32'h8, 32'h1000_0002);
    read_trace("t3_tr3_empty", 4'd3, 32'h0, 32'h0);

    // 3b: halt and timeout on the same cycle -> both flags, 2 cycles.
    max_cycles = 16'd2;
    exp_q.push_back(pack_res(1'b1, 1'b1, 1'b1, 16'd2, 6'd0, 5'd0));
    start_run();
    drive_cycle(32'h4, JMP, 1'b0, 5'd0, 32'd0);
    drive_cycle(32'h4, JMP, 1'b0, 5'd0, 32'd0);
    wait_done("t3b");
    max_cycles = 16'd0;

    // 4: 20 linear cycles, jump-to-self at 0x4C, ring wraps.
    exp_q.push_back(pack_res(1'b1, 1'b0, 1'b1, 16'd21, 6'd0, 5'd0));
    start_run();
    for (int i = 0; i < 20; i++) drive_cycle(32'(4 * i), 32'h1000_0000 + 32'(i), 1'b0, 5'd0, 32'd0);
    drive_cycle(32'h4C, 32'h1000_0013, 1'b0, 5'd0, 32'd0);
    wait_done("t4");
    check("t4_trace_count", trace_count, 5'd16);
    read_trace("t4_tr0", 4'd0, 32'h14, 32'h1000_0005);
    read_trace("t4_tr15", 4'd15, 32'h4C, 32'h1000_0013);

    // 5: write to r0 ignored, expected r0=0 passes.
    clr_exp();
    prog_exp(5'd0, 32'd0);
    exp_q.push_back(pack_res(1'b1, 1'b0, 1'b1, 16'd3, 6'd0, 5'd0));
    start_run();
    drive_cycle(32'h0, ADDI, 1'b1, 5'd0, 32'd7);
    drive_cycle(32'h4, JMP, 1'b0, 5'd0, 32'd0);
    drive_cycle(32'h4, JMP, 1'b0, 5'd0, 32'd0);
    wait_done("t5");

    // 5b: reset mid-run clears everything including the expected table.
    prog_exp(5'd5, 32'd9);
    start_run();
    drive_cycle(32'h0, ADDI, 1'b1, 5'd5, 32'd1);
    reset = 1'b1;
    #1;
    check("midrun_reset_outputs",
          {busy, done, pass, halted, timeout, cycle_count, mismatch_count,
           first_mismatch_reg, trace_count, trace_pc, trace_instr, dbg_state}, '0);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back(pack_res(1'b1, 1'b0, 1'b1, 16'd3, 6'd0, 5'd0));
    start_run();
    drive_cycle(32'h0, ADDI, 1'b1, 5'd5, 32'd1);
    drive_cycle(32'h4, JMP, 1'b0, 5'd0, 32'd0);
    drive_cycle(32'h4, JMP, 1'b0, 5'd0, 32'd0);
    wait_done("t5b");

    // 6: exp_we during RUN and start during CHECK are ignored; CHECK lasts 32 cycles.
    clr_exp();
    prog_exp(5'd2, 32'h22);
    exp_q.push_back(pack_res(1'b1, 1'b0, 1'b1, 16'd3, 6'd0, 5'd0));
    start_run();
    exp_we = 1'b1; exp_addr = 5'd2; exp_data = 32'h99;
    drive_cycle(32'h0, ADDI, 1'b1, 5'd2, 32'h22);
    exp_we = 1'b0;
    drive_cycle(32'h4, JMP, 1'b0, 5'd0, 32'd0);
    drive_cycle(32'h4, JMP, 1'b0, 5'd0, 32'd0);
    check("t6_check_entry_state", dbg_state, ST_CHECK_ENC);
    start = 1'b1;
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      start = 1'b0;
      n++;
    end
    check("t6_check_latency", 32'(n), 32'd32);
    @(posedge clk); #1;

    // 7: exp_we on the start cycle takes effect; r3 never written -> mismatch at r3.
    clr_exp();
    exp_we = 1'b1; exp_addr = 5'd3; exp_data = 32'h33;
    exp_q.push_back(pack_res(1'b1, 1'b0, 1'b0, 16'd2, 6'd1, 5'd3));
    start_run();
    exp_we = 1'b0;
    drive_cycle(32'h0, JMP, 1'b0, 5'd0, 32'd0);
    drive_cycle(32'h0, JMP, 1'b0, 5'd0, 32'd0);
    wait_done("t7");

    repeat (2) @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
